// File: rtl/buff_16_pack.sv
`default_nettype none
// ============================================================================
// Module   : buff_16_pack
// Purpose  : Packs 16 serial PE results into a 4x4 byte tile and writes it
//            to the 32-bit main buffer as row words (partial tiles by flush).
// Revision : 1.0 - initial release
// ============================================================================
module buff_16_pack #(
  parameter int DATA_W = 8,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int ADDR_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic                     flush,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W*COLS-1:0]   wr_data,
  input  logic                     wr_ready,
  output logic                     tile_done
);

  localparam int TILE_N = ROWS * COLS;
  localparam int CNT_W  = $clog2(TILE_N);
  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int RTW_W  = $clog2(ROWS + 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ROW_W-1:0]    row;
  logic [RTW_W-1:0]    rows_to_write;
  logic [ADDR_W-1:0]   base_q;
  logic [DATA_W-1:0]   tile_mem [ROWS][COLS];

  logic                accept;
  logic [CNT_W:0]      cnt_after;
  logic [CNT_W+1:0]    rows_num;
  logic [RTW_W-1:0]    rows_needed;
  logic                last_byte;
  logic                start_drain;
  logic                last_row;
  logic [ROW_W-1:0]    fill_row;
  logic [COL_W-1:0]    fill_col;

  assign accept      = in_valid & in_ready;
  assign cnt_after   = {1'b0, cnt} + {{CNT_W{1'b0}}, accept};
  // ceil(cnt_after / COLS): a full tile naturally yields ROWS
  assign rows_num    = {1'b0, cnt_after} + (CNT_W+2)'(COLS - 1);
  assign rows_needed = RTW_W'(rows_num >> COL_W);
  assign last_byte   = accept && (cnt == CNT_W'(TILE_N - 1));
  assign start_drain = last_byte || (flush && (cnt_after != '0));
  assign last_row    = ((RTW_W'(row) + RTW_W'(1)) == rows_to_write);
  assign fill_row    = cnt[CNT_W-1:COL_W];
  assign fill_col    = cnt[COL_W-1:0];

  // Write-side outputs depend only on registered state
  assign wr_addr = wr_en ? (base_q + ADDR_W'(row)) : '0;

  always_comb begin
    wr_data = '0;
    if (wr_en) begin
      for (int c = 0; c < COLS; c++) begin
        wr_data[c*DATA_W +: DATA_W] = tile_mem[row][c];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= FILL;
      cnt           <= '0;
      row           <= '0;
      rows_to_write <= '0;
      base_q        <= '0;
      in_ready      <= 1'b1;
      wr_en         <= 1'b0;
      tile_done     <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          tile_mem[r][c] <= '0;
        end
      end
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            tile_mem[fill_row][fill_col] <= in_data;
            cnt                          <= cnt_after[CNT_W-1:0];
            if (cnt == '0) begin
              base_q <= base_addr;
            end
          end
          // A flush sharing an edge with a byte includes that byte
          if (start_drain) begin
            state         <= DRAIN;
            rows_to_write <= rows_needed;
            in_ready      <= 1'b0;
            wr_en         <= 1'b1;
          end
        end

        DRAIN: begin
          if (wr_ready) begin
            if (last_row) begin
              state     <= DONE;
              wr_en     <= 1'b0;
              tile_done <= 1'b1;
            end else begin
              row <= row + ROW_W'(1);
            end
          end
        end

        DONE: begin
          state     <= FILL;
          tile_done <= 1'b0;
          in_ready  <= 1'b1;
          cnt       <= '0;
          row       <= '0;
          // Clearing here is what zero-pads the next partial tile
          for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
              tile_mem[r][c] <= '0;
            end
          end
        end

        default: begin
          state     <= FILL;
          in_ready  <= 1'b1;
          wr_en     <= 1'b0;
          tile_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_buff_16_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_buff_16_pack
// Purpose  : Self-checking bench for buff_16_pack against a tile-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_buff_16_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [5:0]  base_addr;
  logic        flush;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        tile_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  tb_bytes [16];
  logic [5:0]  got_addr [$];
  logic [31:0] got_data [$];
  int          done_pulses;
  int          row1_cycles;
  logic        prev_stall;
  logic [5:0]  prev_addr;
  logic [31:0] prev_data;

  buff_16_pack #(.DATA_W(8), .ROWS(4), .COLS(4), .ADDR_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .base_addr (base_addr),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .tile_done (tile_done)
  );

  always #5 clk = ~clk;

  // Expected row word: bytes of row r, zero beyond the n bytes supplied
  function automatic logic [31:0] exp_word(input int r, input int n);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (4*r + k < n) w = w | (32'(tb_bytes[4*r + k]) << (8*k));
    end
    return w;
  endfunction

  // Bus monitor on the falling edge
  initial begin
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          n_checks++;
          if (wr_en !== 1'b1 || wr_addr !== prev_addr || wr_data !== prev_data) begin
            n_fail++;
            $display("FAIL stall_hold: got en=%0b addr=%0d data=%h, need en=1 addr=%0d data=%h",
                     wr_en, wr_addr, wr_data, prev_addr, prev_data);
          end
        end
        if (wr_en === 1'b1) begin
          n_checks++;
          if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL in_ready_during_drain: got %b, need 0", in_ready);
          end
          if (got_addr.size() == 1) row1_cycles++;
        end
        if (wr_en === 1'b1 && wr_ready === 1'b1) begin
          got_addr.push_back(wr_addr);
          got_data.push_back(wr_data);
        end
        if (tile_done === 1'b1) done_pulses++;
        prev_stall = (wr_en === 1'b1) && (wr_ready !== 1'b1);
        prev_addr  = wr_addr;
        prev_data  = wr_data;
      end
    end
  end

  task automatic clear_obs();
    got_addr.delete();
    got_data.delete();
    done_pulses = 0;
    row1_cycles = 0;
  endtask

  // fmode: 0 none, 1 flush with last byte, 2 flush after last byte
  // gmode: 0 continuous, 1 alternate, 2 random; rmode: 0 high, 1 random, 2 stall row 1
  task automatic run_tile(input logic [5:0] base, input int n, input int fmode,
                          input int gmode, input int rmode, input bit scramble,
                          input string name);
    int  i, t, stalls, rows;
    bit  v, acc;
    logic [5:0] ea;
    clear_obs();
    rows = (n + 3) / 4;
    base_addr = base;
    i = 0;
    t = 0;
    while (i < n && t < 1000) begin
      v = (gmode == 0) ? 1'b1 : (gmode == 1) ? (t % 2 == 0) : ($urandom_range(0, 2) != 0);
      in_valid = v;
      in_data  = v ? tb_bytes[i] : 8'($urandom);
      flush    = (fmode == 1) && v && (i == n - 1);
      acc      = v && (in_ready === 1'b1);
      @(posedge clk); #1;
      t++;
      if (acc) begin
        if (i == 0 && scramble) base_addr = 6'($urandom);
        i++;
      end
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    n_checks++;
    if (i != n) begin
      n_fail++;
      $display("FAIL %s accept_timeout: got %0d bytes, need %0d", name, i, n);
    end
    if (fmode == 2 && n < 16) begin
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
    end
    n_checks++;
    if (wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL %s first_write_latency: got wr_en=%b, need 1", name, wr_en);
    end
    t = 0;
    stalls = 0;
    while (tile_done !== 1'b1 && t < 500) begin
      case (rmode)
        0: wr_ready = 1'b1;
        1: wr_ready = 1'($urandom);
        default: begin
          if (got_addr.size() == 1 && stalls < 3) begin
            wr_ready = 1'b0;
            stalls++;
          end else begin
            wr_ready = 1'b1;
          end
        end
      endcase
      @(posedge clk); #1;
      t++;
    end
    wr_ready = 1'b1;
    n_checks++;
    if (tile_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s tile_done_timeout: got tile_done=%b, need 1", name, tile_done);
    end
    if (rmode == 0) begin
      n_checks++;
      if (t != rows) begin
        n_fail++;
        $display("FAIL %s drain_cycles: got %0d, need %0d", name, t, rows);
      end
    end
    if (rmode == 2) begin
      n_checks++;
      if (row1_cycles != 4) begin
        n_fail++;
        $display("FAIL %s row1_hold_cycles: got %0d, need 4", name, row1_cycles);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (tile_done !== 1'b0 || in_ready !== 1'b1 || wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_done: got done=%b rdy=%b en=%b, need 0 1 0",
               name, tile_done, in_ready, wr_en);
    end
    n_checks++;
    if (done_pulses != 1) begin
      n_fail++;
      $display("FAIL %s done_pulses: got %0d, need 1", name, done_pulses);
    end
    n_checks++;
    if (got_addr.size() != rows) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d, need %0d", name, got_addr.size(), rows);
    end else begin
      for (int r = 0; r < rows; r++) begin
        ea = 6'((int'(base) + r) % 64);
        n_checks++;
        if (got_addr[r] !== ea || got_data[r] !== exp_word(r, n)) begin
          n_fail++;
          $display("FAIL %s row%0d: got (%0d,%h), need (%0d,%h)",
                   name, r, got_addr[r], got_data[r], ea, exp_word(r, n));
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; base_addr = '0; flush = 1'b0; wr_ready = 1'b1;
    #1;
    n_checks++;
    if (wr_en !== 1'b0 || wr_addr !== 6'd0 || wr_data !== 32'd0 || tile_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b addr=%0d data=%h done=%b, need 0 0 0 0",
               wr_en, wr_addr, wr_data, tile_done);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b en=%b, need 1 0", in_ready, wr_en);
    end
  endtask

  task automatic test_full_tile();
    for (int k = 0; k < 16; k++) tb_bytes[k] = 8'(k + 1);
    run_tile(6'd8, 16, 0, 0, 0, 1'b0, "full_tile");
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 16; k++) tb_bytes[k] = 8'(k + 1);
    run_tile(6'd8, 16, 0, 0, 2, 1'b0, "backpressure");
  endtask

  task automatic test_partial_flush();
    for (int k = 0; k < 16; k++) tb_bytes[k] = 8'(8'hA1 + k);
    run_tile(6'd20, 6, 2, 0, 0, 1'b0, "partial_flush");
    for (int k = 0; k < 16; k++) tb_bytes[k] = 8'(8'h31 + k);
    run_tile(6'd30, 3, 2, 0, 0, 1'b0, "after_flush_clear");
  endtask

  task automatic test_flush_edges();
    clear_obs();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (got_addr.size() != 0 || done_pulses != 0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_empty: got writes=%0d done=%0d rdy=%b, need 0 0 1",
               got_addr.size(), done_pulses, in_ready);
    end
    for (int k = 0; k < 16; k++) tb_bytes[k] = 8'(8'hB1 + k);
    run_tile(6'd40, 7, 1, 0, 0, 1'b0, "flush_with_7th");
    for (int k = 0; k < 16; k++) tb_bytes[k] = 8'(8'hC1 + k);
    run_tile(6'd44, 16, 1, 0, 0, 1'b0, "flush_with_16th");
  endtask

  task automatic test_wrap_gaps();
    for (int k = 0; k < 16; k++) tb_bytes[k] = 8'(8'h51 + 3*k);
    run_tile(6'd62, 16, 0, 1, 0, 1'b1, "wrap_gaps");
  endtask

  task automatic test_reset_mid_drain();
    base_addr = 6'd5;
    wr_ready  = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h70 + k);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 6'd6) begin
      n_fail++;
      $display("FAIL mid_drain_row1: got en=%b addr=%0d, need 1 6", wr_en, wr_addr);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (wr_en !== 1'b0 || wr_addr !== 6'd0 || wr_data !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: got en=%b addr=%0d data=%h, need 0 0 0", wr_en, wr_addr, wr_data);
    end
    clear_obs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || got_addr.size() != 0 || done_pulses != 0) begin
      n_fail++;
      $display("FAIL reset_discard: got rdy=%b writes=%0d done=%0d, need 1 0 0",
               in_ready, got_addr.size(), done_pulses);
    end
    for (int k = 0; k < 16; k++) tb_bytes[k] = 8'(8'hE0 + k);
    run_tile(6'd0, 16, 0, 0, 0, 1'b0, "post_reset_tile");
  endtask

  task automatic test_random();
    int n, fm;
    for (int it = 0; it < 12; it++) begin
      n  = $urandom_range(1, 16);
      fm = (n == 16) ? $urandom_range(0, 1) : $urandom_range(1, 2);
      for (int k = 0; k < 16; k++) tb_bytes[k] = 8'($urandom);
      run_tile(6'($urandom), n, fm, 2, 1, 1'b1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_full_tile();
    test_backpressure();
    test_partial_flush();
    test_flush_edges();
    test_wrap_gaps();
    test_reset_mid_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
